// File: rtl/led_pkg.sv
// Shared types and constants for the LED/BNC indicator pattern sequencer.
package led_pkg;

  localparam int CODE_W = 4;
  localparam int IDX_W  = 3;

  typedef logic [CODE_W-1:0] code_t;

  typedef enum logic {
    STOPPED = 1'b0,
    RUNNING = 1'b1
  } seq_state_t;

  localparam code_t RESET_CODE_DEFAULT = 4'b1011;

  // Entry 0 holds the board's reset code; the rest form a walking-one pattern.
  function automatic code_t reset_entry(input logic [IDX_W-1:0] i, input code_t code0);
    code_t one;
    one = 4'b0001;
    if (i == '0) return code0;
    return one << i[1:0];
  endfunction

endpackage

// File: rtl/led_prescaler.sv
// Free-running divider: pulses tick once every STEP_DIV enabled cycles.
module led_prescaler #(
  parameter int STEP_DIV = 50000000,
  parameter int DIV_W    = 27
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam logic [DIV_W-1:0] LAST = DIV_W'(STEP_DIV - 1);

  logic [DIV_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + DIV_W'(1);
    end
  end

  // A clear wins over the wrap so a state change never also produces a step.
  assign tick = en && !clr && (cnt == LAST);

endmodule

// File: rtl/led_pattern_sequencer.sv
// Programmable 8-entry indicator pattern table, stepped automatically or on command.
module led_pattern_sequencer
  import led_pkg::*;
#(
  parameter int    STEP_DIV   = 50000000,
  parameter int    DIV_W      = 27,
  parameter int    DEPTH      = 8,
  parameter code_t RESET_CODE = RESET_CODE_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             step,
  input  logic [IDX_W-1:0] last_idx,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_addr,
  input  code_t            wr_data,
  output code_t            code,
  output logic [IDX_W-1:0] index,
  output logic             tick
);

  // Handshake: none. step and wr_en are single-cycle strobes sampled on every
  // rising clk edge; there is no ready/backpressure path.

  seq_state_t       state, state_next;
  logic             presc_en, presc_clr, presc_tick;
  logic             advance;
  logic [IDX_W-1:0] idx_next;
  code_t            pat_tbl [DEPTH];

  led_prescaler #(
    .STEP_DIV (STEP_DIV),
    .DIV_W    (DIV_W)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (presc_en),
    .clr  (presc_clr),
    .tick (presc_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= STOPPED;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      STOPPED: if (run)  state_next = RUNNING;
      RUNNING: if (!run) state_next = STOPPED;
      default:           state_next = STOPPED;
    endcase
  end

  always_comb begin
    presc_en  = (state == RUNNING);
    presc_clr = (state_next != state);
    advance   = (state == STOPPED) ? step : presc_tick;
  end

  always_comb begin
    idx_next = index;
    if (advance) idx_next = (index >= last_idx) ? '0 : index + IDX_W'(1);
  end

  // code is read from the pre-write table, so a same-cycle write to the newly
  // selected entry shows up one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      index <= '0;
      tick  <= 1'b0;
      code  <= RESET_CODE;
      for (int i = 0; i < DEPTH; i++) pat_tbl[i] <= reset_entry(IDX_W'(i), RESET_CODE);
    end else begin
      index <= idx_next;
      tick  <= advance;
      code  <= pat_tbl[idx_next];
      if (wr_en) pat_tbl[wr_addr] <= wr_data;
    end
  end

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Self-checking bench for led_pattern_sequencer: directed scenarios plus random traffic vs a reference model.
module tb_led_pattern_sequencer;

  localparam int STEP_DIV = 4;
  localparam int DIV_W    = 27;

  logic       clk = 1'b0;
  logic       rst, run, step, wr_en;
  logic [2:0] last_idx, wr_addr;
  logic [3:0] wr_data;
  logic [3:0] code;
  logic [2:0] index;
  logic       tick;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  bit         m_running;
  int         m_since;
  int         m_idx;
  bit         m_tick;
  logic [3:0] m_code;
  logic [3:0] m_tbl [8];

  logic [3:0] exp_q[$];

  // clock / reset block
  always #5 clk = ~clk;

  led_pattern_sequencer #(
    .STEP_DIV   (STEP_DIV),
    .DIV_W      (DIV_W),
    .DEPTH      (8),
    .RESET_CODE (4'b1011)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .step     (step),
    .last_idx (last_idx),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .code     (code),
    .index    (index),
    .tick     (tick)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: a walking-one table, an advance every STEP_DIV-th cycle spent
  // running, step only honoured while stopped, code read before the write lands.
  task automatic model_edge();
    logic [3:0] one;
    bit adv;
    one = 4'b0001;
    adv = 1'b0;
    if (rst) begin
      m_running = 1'b0;
      m_since   = 0;
      m_idx     = 0;
      m_tick    = 1'b0;
      m_code    = 4'b1011;
      for (int i = 0; i < 8; i++) m_tbl[i] = (i == 0) ? 4'b1011 : one << (i % 4);
      return;
    end
    if (!m_running) begin
      adv = step;
      if (run) begin
        m_running = 1'b1;
        m_since   = 0;
      end
    end else if (!run) begin
      m_running = 1'b0;
      m_since   = 0;
    end else begin
      m_since++;
      adv = (m_since % STEP_DIV) == 0;
    end
    if (adv) m_idx = (m_idx >= int'(last_idx)) ? 0 : m_idx + 1;
    m_code = m_tbl[m_idx];
    if (wr_en) m_tbl[wr_addr] = wr_data;
    m_tick = adv;
  endtask

  // driver: one clock with the currently driven inputs, then compare vs model
  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("code",  code,  m_code);
    check("index", index, m_idx);
    check("tick",  tick,  m_tick);
  endtask

  task automatic idle_inputs();
    step    = 1'b0;
    wr_en   = 1'b0;
    wr_addr = 3'd0;
    wr_data = 4'd0;
  endtask

  task automatic do_step();
    step = 1'b1;
    cycle();
    step = 1'b0;
  endtask

  initial begin
    int ticks;
    int n;
    bit seen;

    rst = 1'b1; run = 1'b0; last_idx = 3'd7;
    idle_inputs();
    @(negedge clk);
    cycle();
    cycle();
    rst = 1'b0;

    // reset state held while stopped
    for (int i = 0; i < 20; i++) cycle();
    check("rst_code",  code,  4'b1011);
    check("rst_index", index, 3'd0);
    check("rst_tick",  tick,  1'b0);

    // automatic stepping through the whole table
    exp_q = {4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b1011};
    run   = 1'b1;
    ticks = 0;
    for (int i = 0; i < 1 + 8 * STEP_DIV; i++) begin
      cycle();
      if (tick === 1'b1) begin
        ticks++;
        if (exp_q.size() == 0) check("run_extra_tick", 1, 0);
        else                   check("run_seq", code, exp_q.pop_front());
      end
    end
    check("run_ticks", ticks, 8);
    check("run_wrap_index", index, 3'd0);
    check("run_wrap_code", code, 4'b1011);

    // stop and single-step
    run = 1'b0;
    cycle();
    for (int k = 1; k <= 3; k++) begin
      do_step();
      check("step_tick", tick, 1'b1);
      check("step_index", index, k);
      cycle();
      check("step_tick_low", tick, 1'b0);
    end
    ticks = 0;
    for (int i = 0; i < 50; i++) begin
      cycle();
      if (tick === 1'b1) ticks++;
    end
    check("stopped_no_ticks", ticks, 0);
    check("stopped_index", index, 3'd3);

    // lowering last_idx below the current index wraps on the next step
    do_step();
    do_step();
    check("at_index5", index, 3'd5);
    last_idx = 3'd2;
    do_step();
    check("lowered_wrap_index", index, 3'd0);
    check("lowered_wrap_code", code, 4'b1011);

    // write the entry currently shown
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 4'b1111;
    cycle();
    idle_inputs();
    check("wr_cur_old", code, 4'b1011);
    cycle();
    check("wr_cur_new", code, 4'b1111);

    // write and step to the same target in one cycle: read-before-write
    wr_en = 1'b1; wr_addr = 3'd1; wr_data = 4'b1111; step = 1'b1;
    cycle();
    idle_inputs();
    check("wr_step_index", index, 3'd1);
    check("wr_step_old", code, 4'b0010);
    cycle();
    check("wr_step_new", code, 4'b1111);

    // reset mid-run, with a write pending during reset
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 4'b0000;
    cycle();
    idle_inputs();
    last_idx = 3'd7;
    run = 1'b1;
    for (int i = 0; i < 6; i++) cycle();
    rst = 1'b1;
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 4'b0000;
    cycle();
    check("midrst_code",  code,  4'b1011);
    check("midrst_index", index, 3'd0);
    check("midrst_tick",  tick,  1'b0);
    rst = 1'b0; run = 1'b0;
    idle_inputs();
    cycle();
    check("midrst_table0", code, 4'b1011);
    run  = 1'b1;
    seen = 1'b0;
    n    = 0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      cycle();
      if (tick === 1'b1) begin
        seen = 1'b1;
        n    = i;
      end
    end
    check("rerun_tick_seen", seen, 1'b1);
    // the edge that samples run high is number 1; the tick follows STEP_DIV edges later
    check("rerun_first_tick", n - 1, STEP_DIV);

    // randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 15) == 0) run = ~run;
      step  = ($urandom_range(0, 2) == 0);
      wr_en = ($urandom_range(0, 3) == 0);
      wr_addr = 3'($urandom_range(0, 7));
      wr_data = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 19) == 0) last_idx = 3'($urandom_range(0, 7));
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/led_pattern_sequencer.md
Name: led_pattern_sequencer

Overview:
- Upstream stage for the board LED/BNC indicator driver. Produces the 4-bit indicator code that the driver consumes; the driver inverts it for the active-low LEDs and passes it straight to the BNC outputs.
- Replaces a fixed constant code with a programmable 8-entry pattern table.
- Steps through the table automatically at a prescaled rate, or one entry at a time on command.
- Used for board bring-up and for scope triggering on the BNC outputs.

Parameters:
- STEP_DIV, 50000000: clk cycles per automatic advance; legal range 2..2^DIV_W-1.
- DIV_W, 27: prescaler counter width.
- DEPTH, 8: number of pattern table entries; fixed at 8, so the index is 3 bits.
- RESET_CODE, 4'b1011: reset contents of table entry 0.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- run  in  1  level: 1 = automatic stepping, 0 = stopped.
- step  in  1  single-cycle pulse: advance one entry; acted on only while stopped.
- last_idx  in  3  index of the final entry before wrap.
- wr_en  in  1  table write strobe.
- wr_addr  in  3  table write address.
- wr_data  in  4  table write data.
- code  out  4  current indicator code, active-high, to the driver.
- index  out  3  index of the entry currently shown.
- tick  out  1  one-cycle pulse in the cycle the index advances.

Behaviour:
- Reset values:
  - code = RESET_CODE, index = 0, tick = 0.
  - Prescaler = 0, state = STOPPED.
  - Table: entry 0 = RESET_CODE; entry i (i = 1..7) = 4'b0001 << (i mod 4).
- States:
  - STOPPED -> RUNNING when run = 1.
  - RUNNING -> STOPPED when run = 0.
  - Every transition clears the prescaler to 0 in the same cycle.
- Prescaler, RUNNING only:
  - Counts 0..STEP_DIV-1.
  - At STEP_DIV-1 it returns to 0 and an advance occurs.
  - First advance comes STEP_DIV cycles after entering RUNNING.
- step:
  - In STOPPED, step = 1 causes an advance in that cycle.
  - In RUNNING, step is ignored.
  - step held high while stopped advances every cycle.
- Advance rule:
  - If index >= last_idx, index <= 0; otherwise index <= index + 1.
  - If last_idx is lowered below the current index, the next advance wraps to 0.
  - last_idx = 0 holds index at 0, but tick still pulses on each advance.
- tick: registered; high in the cycle index takes its new value.
- code:
  - code = table[index], registered, combining the current table and index each cycle.
  - It tracks index with zero added latency: the new code and new index appear in the same cycle.
  - A write to the entry currently shown updates code one cycle after wr_en.
- Write port:
  - wr_en = 1 writes wr_data to table[wr_addr] at the clock edge.
  - A write and an advance in the same cycle both take effect.
  - When a write targets the newly selected index in that same cycle, code shows the old table value for one cycle, then the new value (read-before-write).
- Reset mid-operation: the table is restored to its reset contents, state returns to STOPPED, and any pending write is dropped.
- Width: the prescaler compare is against STEP_DIV-1 truncated to DIV_W; STEP_DIV must fit in DIV_W.

Decomposition:
- Shared package led_pkg holds:
  - CODE_W = 4 and IDX_W = 3.
  - Typedef code_t [3:0].
  - Enum seq_state_t {STOPPED, RUNNING}.
  - Constant RESET_CODE_DEFAULT = 4'b1011.
- One sub-module, led_prescaler: enable plus clear in, tick out, parameterised by STEP_DIV and DIV_W.
- Table, FSM and index logic stay in the top level.

Test Plan:
- Reset, run = 0, STEP_DIV = 4: code = 4'b1011, index = 0 and tick = 0, held for 20 cycles.
- run = 1, last_idx = 7, STEP_DIV = 4:
  - index advances every 4 cycles with one tick per advance.
  - code sequence is 1011, 0010, 0100, 1000, 0001, 0010, 0100, 1000, then wraps to 1011.
- run = 0, step pulsed 3 times: index goes 0->1->2->3; tick pulses align with each step; no free-running advance in 50 idle cycles.
- Stopped at index 5, last_idx set to 2, then step: index = 0 and code = 1011.
- Write wr_addr = index, wr_data = 4'b1111 while stopped: code = 1111 on the cycle after wr_en. Write and step to the same target in the same cycle: old value for one cycle, then 1111.
- rst asserted mid-run after writing entry 0 = 0000: the next cycle shows code = 1011, index = 0, prescaler cleared; the first tick comes STEP_DIV cycles after run is re-asserted.
